multi_edge_detect: RTL and testbench

Parametrised, multi-channel successor to the single-channel edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable stable time, and reports registered single-cycle rising/falling pulses. It also provides a filtered level and a saturating per-channel edge counter. It sits between external detector/trigger pins and the acquisition and control logic.

---
 rtl/multi_edge_detect.sv | 111 +++++++++++
 tb/tb_multi_edge_detect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, stable-time glitch filter,
// registered rise/fall pulses and a saturating edge counter.
module multi_edge_detect #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       en,
  input  logic [CH-1:0]       sig_in,
  input  logic [1:0]          cnt_mode,
  input  logic                cnt_clr,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       rising,
  output logic [CH-1:0]       falling,
  output logic                any_edge,
  output logic [CH*CNT_W-1:0] edge_cnt,
  output logic [CH-1:0]       cnt_ovf
);

  localparam int FC_W = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [FC_W-1:0]        fc_q, fc_d;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   ovf_q, ovf_d;
      logic                   s;
      logic                   sel;

      assign s = sync_q[SYNC_STAGES-1];

      // Disable forces the filter to idle low; the pulse mask below keeps that
      // forced drop from looking like a falling edge.
      always_comb begin
        fc_d    = fc_q;
        level_d = level_q;
        if (!en[gi]) begin
          fc_d    = '0;
          level_d = 1'b0;
        end else if (s == level_q) begin
          fc_d = '0;
        end else if (fc_q == FC_LAST) begin
          level_d = s;
          fc_d    = '0;
        end else begin
          fc_d = fc_q + FC_W'(1);
        end
        rise_d = en[gi] & level_d & ~level_q;
        fall_d = en[gi] & ~level_d & level_q;
      end

      // The counter looks at the registered pulses, so it lags them by one cycle.
      always_comb begin
        unique case (cnt_mode)
          2'b00:   sel = rise_q;
          2'b01:   sel = fall_q;
          2'b10:   sel = rise_q | fall_q;
          default: sel = 1'b0;
        endcase
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_clr) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (sel) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q  <= '0;
          fc_q    <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end else begin
          if (!en[gi]) sync_q <= '0;
          else         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
          fc_q    <= fc_d;
          level_q <= level_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
        end
      end

      assign level[gi]                    = level_q;
      assign rising[gi]                   = rise_q;
      assign falling[gi]                  = fall_q;
      assign edge_cnt[gi*CNT_W +: CNT_W]  = cnt_q;
      assign cnt_ovf[gi]                  = ovf_q;
    end
  endgenerate

  assign any_edge = |(rising | falling);

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect (4 channels, default sync/filter, 4-bit counters).
module tb_multi_edge_detect;
  localparam int CH = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   en, sig_in;
  logic [1:0]      cnt_mode;
  logic            cnt_clr;
  logic [CH-1:0]   level, rising, falling, cnt_ovf;
  logic            any_edge;
  logic [CH*CW-1:0] edge_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .cnt_mode(cnt_mode),
    .cnt_clr(cnt_clr), .level(level), .rising(rising), .falling(falling),
    .any_edge(any_edge), .edge_cnt(edge_cnt), .cnt_ovf(cnt_ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return edge_cnt[i*CW +: CW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = '1; sig_in = '0; cnt_mode = 2'b00; cnt_clr = 1'b0;
    tick(2);
    n_checks++;
    if ({level, rising, falling, any_edge, cnt_ovf} !== 17'h0) begin
      n_fail++; $display("FAIL reset_flags: got %h expected 0", {level, rising, falling, any_edge, cnt_ovf});
    end
    n_checks++;
    if (edge_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected 0000", edge_cnt);
    end
    rst_n = 1'b1;
    tick(3);
    $display("test_reset done");
  endtask

  task automatic test_single_rise();
    sig_in[0] = 1'b1;
    tick(4);
    n_checks++;
    if (rising !== 4'h0) begin n_fail++; $display("FAIL rise_early: got %b expected 0000", rising); end
    tick(1);
    n_checks++;
    if (rising !== 4'b0001 || level !== 4'b0001 || falling !== 4'h0 || any_edge !== 1'b1) begin
      n_fail++; $display("FAIL rise_pulse: rising=%b level=%b falling=%b any=%b expected 0001/0001/0000/1",
                         rising, level, falling, any_edge);
    end
    tick(1);
    n_checks++;
    if (rising !== 4'h0 || any_edge !== 1'b0 || level !== 4'b0001) begin
      n_fail++; $display("FAIL rise_one_cycle: rising=%b any=%b level=%b", rising, any_edge, level);
    end
    n_checks++;
    if (edge_cnt !== 16'h0001 || cnt_ovf !== 4'h0) begin
      n_fail++; $display("FAIL rise_count: got %h ovf %b expected 0001 ovf 0000", edge_cnt, cnt_ovf);
    end
    tick(4);
    sig_in[0] = 1'b0;
    tick(8);
    n_checks++;
    if (level !== 4'h0 || edge_cnt !== 16'h0001) begin
      n_fail++; $display("FAIL fall_not_counted: level=%b cnt=%h expected 0000/0001", level, edge_cnt);
    end
    $display("test_single_rise done");
  endtask

  task automatic test_glitch();
    int nr, nf, nl, rise_at, fall_at;
    nr = 0; nf = 0; nl = 0; rise_at = 0; fall_at = 0;
    sig_in[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (rising[1]) nr++;
      if (falling[1]) nf++;
      if (level[1]) nl++;
      if (k == 2) sig_in[1] = 1'b0;
    end
    n_checks++;
    if (nr != 0 || nf != 0 || nl != 0) begin
      n_fail++; $display("FAIL glitch_2cyc: rises=%0d falls=%0d level_hi=%0d expected 0/0/0", nr, nf, nl);
    end
    nr = 0; nf = 0;
    sig_in[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (rising[1]) begin nr++; rise_at = k; end
      if (falling[1]) begin nf++; fall_at = k; end
      if (k == 3) sig_in[1] = 1'b0;
    end
    n_checks++;
    if (nr != 1 || nf != 1 || rise_at != 5 || fall_at != 8) begin
      n_fail++; $display("FAIL glitch_3cyc: rises=%0d@%0d falls=%0d@%0d expected 1@5 1@8", nr, rise_at, nf, fall_at);
    end
    n_checks++;
    if (cnt_of(1) !== 4'd1) begin n_fail++; $display("FAIL glitch_count: got %0d expected 1", cnt_of(1)); end
    $display("test_glitch done");
  endtask

  task automatic test_mode_both();
    int np;
    np = 0;
    cnt_mode = 2'b10;
    for (int p = 0; p < 5; p++) begin
      sig_in[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin tick(1); if (rising[2] || falling[2]) np++; end
      sig_in[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(1); if (rising[2] || falling[2]) np++; end
    end
    n_checks++;
    if (cnt_of(2) !== 4'd10 || np != 10) begin
      n_fail++; $display("FAIL mode_both: cnt=%0d pulses=%0d expected 10/10", cnt_of(2), np);
    end
    cnt_mode = 2'b11;
    np = 0;
    for (int p = 0; p < 3; p++) begin
      sig_in[2] = 1'b1;
      for (int k = 0; k < 6; k++) begin tick(1); if (rising[2] || falling[2]) np++; end
      sig_in[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin tick(1); if (rising[2] || falling[2]) np++; end
    end
    n_checks++;
    if (cnt_of(2) !== 4'd10 || np != 6) begin
      n_fail++; $display("FAIL mode_frozen: cnt=%0d pulses=%0d expected 10/6", cnt_of(2), np);
    end
    $display("test_mode_both done");
  endtask

  task automatic test_saturate();
    cnt_mode = 2'b00;
    for (int p = 0; p < 15; p++) begin
      sig_in[3] = 1'b1; tick(5); sig_in[3] = 1'b0; tick(5);
    end
    tick(2);
    n_checks++;
    if (cnt_of(3) !== 4'd15 || cnt_ovf !== 4'b0000) begin
      n_fail++; $display("FAIL sat_full: cnt=%0d ovf=%b expected 15/0000", cnt_of(3), cnt_ovf);
    end
    for (int p = 0; p < 2; p++) begin
      sig_in[3] = 1'b1; tick(5); sig_in[3] = 1'b0; tick(5);
    end
    tick(2);
    n_checks++;
    if (cnt_of(3) !== 4'd15 || cnt_ovf !== 4'b1000) begin
      n_fail++; $display("FAIL sat_ovf: cnt=%0d ovf=%b expected 15/1000", cnt_of(3), cnt_ovf);
    end
    sig_in[3] = 1'b1;
    tick(5);
    n_checks++;
    if (rising[3] !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: rising[3]=%b expected 1", rising[3]); end
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    n_checks++;
    if (edge_cnt !== 16'h0 || cnt_ovf !== 4'h0) begin
      n_fail++; $display("FAIL clr_priority: cnt=%h ovf=%b expected 0000/0000", edge_cnt, cnt_ovf);
    end
    tick(3);
    n_checks++;
    if (cnt_of(3) !== 4'd0) begin n_fail++; $display("FAIL clr_edge_lost: cnt=%0d expected 0", cnt_of(3)); end
    sig_in[3] = 1'b0;
    tick(8);
    $display("test_saturate done");
  endtask

  task automatic test_enable();
    int nf;
    nf = 0;
    sig_in[0] = 1'b1;
    tick(6);
    n_checks++;
    if (level[0] !== 1'b1) begin n_fail++; $display("FAIL en_level_hi: level[0]=%b expected 1", level[0]); end
    en[0] = 1'b0;
    tick(1);
    n_checks++;
    if (level[0] !== 1'b0 || falling[0] !== 1'b0) begin
      n_fail++; $display("FAIL en_drop: level[0]=%b falling[0]=%b expected 0/0", level[0], falling[0]);
    end
    for (int k = 0; k < 4; k++) begin tick(1); if (falling[0] || rising[0]) nf++; end
    n_checks++;
    if (nf != 0) begin n_fail++; $display("FAIL en_quiet: pulses=%0d expected 0", nf); end
    en[0] = 1'b1;
    tick(4);
    n_checks++;
    if (rising[0] !== 1'b0) begin n_fail++; $display("FAIL reen_early: rising[0]=%b expected 0", rising[0]); end
    tick(1);
    n_checks++;
    if (rising[0] !== 1'b1) begin n_fail++; $display("FAIL reen_rise: rising[0]=%b expected 1", rising[0]); end
    tick(1);
    n_checks++;
    if (cnt_of(0) !== 4'd2) begin n_fail++; $display("FAIL reen_count: cnt=%0d expected 2", cnt_of(0)); end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    sig_in[1] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, rising, falling, any_edge, cnt_ovf} !== 17'h0 || edge_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid: level=%b rise=%b fall=%b any=%b cnt=%h ovf=%b expected all 0",
                         level, rising, falling, any_edge, edge_cnt, cnt_ovf);
    end
    for (int k = 0; k < 3; k++) begin tick(1); if (any_edge || level != 4'h0) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_hold: activity=%0d expected 0", bad); end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 4) begin
        n_checks++;
        if (rising !== 4'h0) begin n_fail++; $display("FAIL rst_early: rising=%b expected 0000", rising); end
      end
      if (k == 5) begin
        n_checks++;
        if (rising !== 4'b0011 || falling !== 4'h0) begin
          n_fail++; $display("FAIL rst_first_edge: rising=%b falling=%b expected 0011/0000", rising, falling);
        end
      end
    end
    tick(1);
    n_checks++;
    if (edge_cnt !== 16'h0011) begin n_fail++; $display("FAIL rst_count: cnt=%h expected 0011", edge_cnt); end
    sig_in = '0;
    tick(8);
    $display("test_reset_mid done");
  endtask

  task automatic test_all_channels();
    sig_in = 4'hF;
    tick(4);
    n_checks++;
    if (rising !== 4'h0) begin n_fail++; $display("FAIL all_early: rising=%b expected 0000", rising); end
    tick(1);
    n_checks++;
    if (rising !== 4'hF || any_edge !== 1'b1) begin
      n_fail++; $display("FAIL all_rise: rising=%b any=%b expected 1111/1", rising, any_edge);
    end
    tick(1);
    n_checks++;
    if (any_edge !== 1'b0 || edge_cnt !== 16'h1122) begin
      n_fail++; $display("FAIL all_count: any=%b cnt=%h expected 0/1122", any_edge, edge_cnt);
    end
    $display("test_all_channels done");
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_mode_both();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_all_channels();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
